// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants, clear FSM state type and sizing helper for dpram_be
package dpram_pkg;
  localparam int RDW_NEW_DATA = 0;
  localparam int RDW_OLD_DATA = 1;
  typedef enum logic [1:0] {IDLE, CLEAR, READY} clr_state_t;
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/dpram_clear_seq.sv
// dpram_clear_seq: post-reset sequencer that walks every address once to fill the RAM
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int addr_width = 10,
  parameter bit clear_on_reset = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  busy,
  output logic                  clr_we,
  output logic [addr_width-1:0] clr_addr
);
  clr_state_t state, state_nx;
  logic [addr_width-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= clear_on_reset ? CLEAR : READY;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + addr_width'(1);
  // leave CLEAR on the edge that writes the last word, so busy spans exactly 2**addr_width cycles
  always_comb
    state_nx = (state == IDLE)          ? (clear_on_reset ? CLEAR : READY) :
               (state == CLEAR && &cnt) ? READY : state;
  always_comb begin
    busy = (state == CLEAR);
    clr_we = busy;
    clr_addr = cnt;
  end
endmodule

// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM with byte enables, RDW mode, optional output register and clear
module dpram_be
  import dpram_pkg::*;
#(
  parameter int                    addr_width     = 10,
  parameter int                    data_width     = 8,
  parameter int                    rdw_mode       = RDW_NEW_DATA,
  parameter bit                    outdata_reg    = 1'b0,
  parameter bit                    clear_on_reset = 1'b1,
  parameter logic [data_width-1:0] clear_value    = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    busy,
  input  logic                    wren_a,
  input  logic                    rden_a,
  input  logic [data_width/8-1:0] byteena_a,
  input  logic [addr_width-1:0]   address_a,
  input  logic [data_width-1:0]   data_a,
  output logic [data_width-1:0]   q_a,
  input  logic                    wren_b,
  input  logic                    rden_b,
  input  logic [data_width/8-1:0] byteena_b,
  input  logic [addr_width-1:0]   address_b,
  input  logic [data_width-1:0]   data_b,
  output logic [data_width-1:0]   q_b
);
  localparam int nb = bytes_of(data_width);
  if (data_width % 8 != 0) begin : g_dw_chk
    $error("dpram_be: data_width must be a multiple of 8");
  end
  if (rdw_mode != RDW_NEW_DATA && rdw_mode != RDW_OLD_DATA) begin : g_rdw_chk
    $error("dpram_be: unsupported rdw_mode");
  end
  logic [data_width-1:0] mem [2**addr_width];
  logic                  clr_we;
  logic [addr_width-1:0] clr_addr;
  logic [data_width-1:0] old_a, old_b, new_a, new_b, q1_a, q1_b;
  dpram_clear_seq #(.addr_width(addr_width), .clear_on_reset(clear_on_reset)) u_clr (
    .clock(clock),
    .reset_n(reset_n),
    .busy(busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  assign old_a = mem[address_a];
  assign old_b = mem[address_b];
  // each port's new-data view only merges its own write; the other port's write is never visible
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < nb; i++) begin
      if (wren_a && byteena_a[i]) new_a[8*i +: 8] = data_a[8*i +: 8];
      if (wren_b && byteena_b[i]) new_b[8*i +: 8] = data_b[8*i +: 8];
    end
  end
  // B is written first so A's later assignment wins on bytes both ports enable
  always_ff @(posedge clock)
    if (clr_we) mem[clr_addr] <= clear_value;
    else
      for (int i = 0; i < nb; i++) begin
        if (wren_b && byteena_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
        if (wren_a && byteena_a[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      q1_a <= '0;
      q1_b <= '0;
    end else begin
      q1_a <= busy ? '0 : !rden_a ? q1_a : (rdw_mode == RDW_NEW_DATA) ? new_a : old_a;
      q1_b <= busy ? '0 : !rden_b ? q1_b : (rdw_mode == RDW_NEW_DATA) ? new_b : old_b;
    end
  if (outdata_reg) begin : g_oreg
    logic [data_width-1:0] q2_a, q2_b;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        q2_a <= '0;
        q2_b <= '0;
      end else begin
        q2_a <= busy ? '0 : q1_a;
        q2_b <= busy ? '0 : q1_b;
      end
    assign q_a = q2_a;
    assign q_b = q2_b;
  end else begin : g_noreg
    assign q_a = q1_a;
    assign q_b = q1_b;
  end
endmodule
